// File: rtl/seq_sched_pkg.sv
// Shared types for the sequential scan scheduler: control states, match-core
// state codes and the count-width helper.
package seq_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        RESP  = 2'd2
    } ctrl_state_e;

    // Match-core states, named by the input suffix they track
    localparam logic [2:0] S0 = 3'd0;  // start
    localparam logic [2:0] S1 = 3'd1;  // "1"
    localparam logic [2:0] S2 = 3'd2;  // "10"
    localparam logic [2:0] S3 = 3'd3;  // "0"
    localparam logic [2:0] S4 = 3'd4;  // "01"
    localparam logic [2:0] S5 = 3'd5;  // "100"

    function automatic int cnt_width(input int word_w);
        return $clog2(word_w + 1);
    endfunction

endpackage

// File: rtl/seq_match_core.sv
// Overlapping Mealy detector for 1001 and 010; match is combinational on the
// current state and the presented bit.
module seq_match_core
    import seq_sched_pkg::*;
(
    input  logic clk,
    input  logic rstn,
    input  logic clr,
    input  logic en,
    input  logic bit_in,
    output logic match
);

    logic [2:0] state_q, state_d, nxt;

    always_comb begin
        nxt = S0;
        case (state_q)
            S0:      nxt = bit_in ? S1 : S3;
            S1:      nxt = bit_in ? S1 : S2;
            S2:      nxt = bit_in ? S4 : S5;
            S3:      nxt = bit_in ? S4 : S3;
            S4:      nxt = bit_in ? S1 : S2;
            S5:      nxt = bit_in ? S4 : S3;
            default: nxt = S0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        if (clr)
            state_d = S0;
        else if (en)
            state_d = nxt;
    end

    assign match = ((state_q == S4) && !bit_in) || ((state_q == S5) && bit_in);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            state_q <= S0;
        else
            state_q <= state_d;
    end

endmodule

// File: rtl/seq_scan_sched.sv
// Round-robin scheduler that serialises one requester word at a time through
// the match core and returns its match count. Define SEQ_SCHED_FLUSH_EN to
// restart the match core on every accepted word.
module seq_scan_sched
    import seq_sched_pkg::*;
#(
    parameter int N_REQ  = 4,
    parameter int WORD_W = 8
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic [N_REQ-1:0]             req_valid,
    input  logic [N_REQ*WORD_W-1:0]      req_data,
    output logic [N_REQ-1:0]             req_ready,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [$clog2(N_REQ)-1:0]     rsp_id,
    output logic [$clog2(WORD_W+1)-1:0]  rsp_count,
    output logic                         busy
);

    localparam int IDX_W = $clog2(N_REQ);
    localparam int CNT_W = cnt_width(WORD_W);
    localparam int BC_W  = $clog2(WORD_W);

    ctrl_state_e       state_q, state_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic [IDX_W-1:0]  last_q, last_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [BC_W-1:0]   bcnt_q, bcnt_d;

    logic             win_found;
    logic [IDX_W-1:0] win_idx;
    logic             accept;
    logic             core_en;
    logic             core_clr;
    logic             match;
    int               j;

    // Search starts one past the last grant so every requester gets a turn
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        j         = 0;
        for (int k = 1; k <= N_REQ; k++) begin
            j = (int'(last_q) + k) % N_REQ;
            if (!win_found && req_valid[IDX_W'(j)]) begin
                win_found = 1'b1;
                win_idx   = IDX_W'(j);
            end
        end
    end

    assign accept  = (state_q == IDLE) && win_found;
    assign core_en = (state_q == SHIFT);

`ifdef SEQ_SCHED_FLUSH_EN
    assign core_clr = accept;
`else
    assign core_clr = 1'b0;
`endif

    always_comb begin
        req_ready = '0;
        if (accept && rstn)
            req_ready[win_idx] = 1'b1;
    end

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        bcnt_d  = bcnt_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    word_d  = req_data[int'(win_idx)*WORD_W +: WORD_W];
                    last_d  = win_idx;
                    cnt_d   = '0;
                    bcnt_d  = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                word_d = {word_q[WORD_W-2:0], 1'b0};
                bcnt_d = bcnt_q + BC_W'(1);
                if (match)
                    cnt_d = cnt_q + CNT_W'(1);
                if (bcnt_q == BC_W'(WORD_W - 1))
                    state_d = RESP;
            end
            RESP: begin
                if (rsp_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            word_q  <= '0;
            last_q  <= IDX_W'(N_REQ - 1);
            cnt_q   <= '0;
            bcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            bcnt_q  <= bcnt_d;
        end
    end

    seq_match_core u_core (
        .clk    (clk),
        .rstn   (rstn),
        .clr    (core_clr),
        .en     (core_en),
        .bit_in (word_q[WORD_W-1]),
        .match  (match)
    );

    assign rsp_valid = (state_q == RESP);
    assign busy      = (state_q != IDLE);
    assign rsp_id    = last_q;
    assign rsp_count = cnt_q;

endmodule

// File: doc/seq_scan_sched.md
SEQ_SCAN_SCHED -- requirements
Module: seq_scan_sched

Interface
REQ-001 The block SHALL have parameter N_REQ, default 4, meaning the number of requesters (2..8).
REQ-002 The block SHALL have parameter WORD_W, default 8, meaning the bits per submitted word (4..32).
REQ-003 The block SHALL have port clk, input, 1, the clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rstn, input, 1, the reset: asynchronous, active-low.
REQ-005 The block SHALL have port req_valid, input, N_REQ, one word-pending flag per requester.
REQ-006 The block SHALL have port req_data, input, N_REQ*WORD_W, the words; requester i occupies bits [i*WORD_W +: WORD_W].
REQ-007 The block SHALL have port req_ready, output, N_REQ, a one-hot accept strobe.
REQ-008 The block SHALL have port rsp_valid, output, 1, meaning a result is pending.
REQ-009 The block SHALL have port rsp_ready, input, 1, meaning the consumer accepts the result.
REQ-010 The block SHALL have port rsp_id, output, $clog2(N_REQ), the requester index of the result.
REQ-011 The block SHALL have port rsp_count, output, $clog2(WORD_W+1), the number of matches in the word.
REQ-012 The block SHALL have port busy, output, 1, high in every state except IDLE.

Function
REQ-013 Control SHALL use states IDLE, SHIFT and RESP.
REQ-014 In IDLE with any req_valid high, the block SHALL select a winner round-robin, starting the search at last_grant+1 (mod N_REQ).
REQ-015 In that cycle the block SHALL drive req_ready one-hot to the winner, combinationally, and capture its word, its index and last_grant; the next state SHALL be SHIFT.
REQ-016 req_ready SHALL be all-zero outside IDLE, and in IDLE when no req_valid is high.
REQ-017 In SHIFT the block SHALL feed the captured word into the match core, MSB first, one bit per cycle, for exactly WORD_W cycles, then go to RESP.
REQ-018 The match core SHALL be a 6-state Mealy detector for overlapping patterns 1001 and 010, with states: S0 start, S1 "1", S2 "10", S3 "0", S4 "01", S5 "100".
REQ-019 Match core transitions, written as (bit=0 / bit=1), SHALL be: S0 -> S3/S1; S1 -> S2/S1; S2 -> S5/S4; S3 -> S3/S4; S4 -> S2/S1; S5 -> S3/S4; any illegal state -> S0.
REQ-020 The match pulse SHALL be (S4 with bit=0) or (S5 with bit=1); each pulse during SHIFT SHALL increment the match count.
REQ-021 The match count SHALL clear on word acceptance and SHALL NOT overflow, because its width is $clog2(WORD_W+1).
REQ-022 In RESP the block SHALL drive rsp_valid=1 with stable rsp_id and rsp_count until rsp_ready=1, then return to IDLE; no word is accepted in that cycle.
REQ-023 Latency SHALL be fixed: a word accepted at cycle T gives rsp_valid first high at T+WORD_W+1.
REQ-024 req_valid or req_data changes during SHIFT or RESP SHALL have no effect.
REQ-025 rsp_id and rsp_count SHALL be don't-care while rsp_valid=0 but SHALL hold their last values.

Reset
REQ-026 On rstn low: state=IDLE, match core=S0, count=0, last_grant=N_REQ-1 (so requester 0 wins first), rsp_valid=0, req_ready=0, busy=0.
REQ-027 Reset asserted mid-SHIFT or mid-RESP SHALL abort the word with no response; that requester must resubmit.

Configuration
REQ-028 With SEQ_SCHED_FLUSH_EN defined, the match core SHALL return to S0 on every word acceptance, so words are detected independently.
REQ-029 Without SEQ_SCHED_FLUSH_EN, the match core state SHALL carry across words as one continuous bit stream, and SHALL reset only on rstn.

Structure
REQ-030 The package seq_sched_pkg SHALL hold the control-state enum, the match-core state localparams S0..S5 and a count-width helper function.
REQ-031 The match core SHALL be a separate sub-module, seq_match_core, with ports clk, rstn, clr, en, bit_in and match.
REQ-032 seq_match_core's match output SHALL be a combinational function of its current state and bit_in.

Verification
REQ-033 A bench SHALL cover the following directed scenarios:
- Scenario 1: flush enabled, req_valid=0001, word 8'b1001_0010, rsp_ready=1 -> rsp_valid at T+9, rsp_id=0, rsp_count=4.
- Scenario 2: flush enabled, req0 sends 8'h01 then 8'h20 -> counts 0 and 1.
- Scenario 3: flush disabled, same two words as Scenario 2 -> counts 0 and 3.
- Scenario 4: all four req_valid held high, rsp_ready=1 -> grant order 0,1,2,3,0; req_ready is one-hot and never high outside IDLE.
- Scenario 5: rsp_ready held low for 5 cycles -> rsp_valid, rsp_id and rsp_count are stable for all 5 cycles; req_ready=0 throughout.
- Scenario 6: rstn pulsed low at the 4th SHIFT cycle -> busy=0 and rsp_valid=0 immediately, no response; the next grant goes to requester 0.
